// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle main control unit.
//   - state encodings (IDLE=0 .. ILLEGAL)
//   - opcode / func constants, alu_op codes, pc_source codes, alu_src_b codes
//   - ctrl_t: the packed bundle of control outputs produced per state
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        ADDI_EXEC = 4'd9,
        ADDI_WB   = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JR        = 4'd13,
        ILLEGAL   = 4'd14
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;

    localparam logic [5:0] FUNC_JR  = 6'b001000;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_SHIMM = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // R-type funcs that go through the ALU execute/writeback path
    function automatic logic is_alu_func(input logic [5:0] f);
        return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_AND) ||
               (f == FUNC_OR)  || (f == FUNC_SLT);
    endfunction

    // States whose exit retires an instruction
    function automatic logic is_terminal(input state_t s);
        return (s == MEM_WB) || (s == MEM_WRITE) || (s == R_WB) ||
               (s == ADDI_WB) || (s == BRANCH) || (s == JUMP) || (s == JR);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: pure state-to-control-outputs decoder.
//   state     : current FSM state
//   is_bne    : latched branch flavour (1 = bne) used in BRANCH
//   mem_ready : (MEM_WAIT_EN only) memory handshake; gates the write strobes
//               of FETCH and MEM_WRITE
//   ctrl      : every datapath select / enable; unlisted fields are 0
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t state,
    input  logic   is_bne,
`ifdef MEM_WAIT_EN
    input  logic   mem_ready,
`endif
    output ctrl_t  ctrl
);

    logic wr_ok;
`ifdef MEM_WAIT_EN
    assign wr_ok = mem_ready;
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = wr_ok;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = wr_ok;
                ctrl.pc_source = PC_ALU;
            end
            DECODE: begin
                // branch target into ALUOut
                ctrl.alu_src_b = ALUB_SHIMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = wr_ok;
                ctrl.iord      = 1'b1;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALU_FUNC;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ADDI_WB: ctrl.reg_write = 1'b1;
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.branch_ne     = is_bne;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_RS;
            end
            ILLEGAL: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle main control FSM (fetch/decode/execute/
// memory/writeback) for the 32-bit datapath.
//   clk, reset (async, active high), opcode/func (sampled in DECODE only),
//   zero (consumed by the datapath's branch gate, not by the FSM)
//   outputs: all datapath selects/enables (Moore), illegal pulse,
//   instret retired-instruction counter, state_o debug view.
// Optional build macro MEM_WAIT_EN adds a mem_ready input; FETCH, MEM_READ
// and MEM_WRITE then stall until mem_ready=1.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 zero,
`ifdef MEM_WAIT_EN
    input  logic                 mem_ready,
`endif
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 branch_ne,
    output logic [1:0]           pc_source,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state_o
);

    state_t     state, next;
    logic [2:0] op_q;   // opcode captured in DECODE; later states use this
    logic       mem_ok;
    ctrl_t      ctrl;

    // zero only qualifies pc_write_cond inside the datapath
    logic unused_zero;
    assign unused_zero = zero;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            instret <= '0;
        end else begin
            state <= next;
            if (state == DECODE)
                op_q <= opcode;
            // MEM_WRITE may be stalled; count only on the edge it leaves
            if (is_terminal(state) && (state != MEM_WRITE || mem_ok))
                instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   next = FETCH;
            FETCH:  if (mem_ok) next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (func == FUNC_JR)       next = JR;
                        else if (is_alu_func(func)) next = R_EXEC;
                        else                        next = ILLEGAL;
                    end
                    OP_ADDI:       next = ADDI_EXEC;
                    OP_LW, OP_SW:  next = MEM_ADDR;
                    OP_BEQ, OP_BNE: next = BRANCH;
                    OP_J:          next = JUMP;
                    default:       next = ILLEGAL;
                endcase
            end
            MEM_ADDR:  next = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ok) next = MEM_WB;
            MEM_WRITE: if (mem_ok) next = FETCH;
            R_EXEC:    next = R_WB;
            ADDI_EXEC: next = ADDI_WB;
            MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, JR, ILLEGAL: next = FETCH;
            default:   next = IDLE;
        endcase
    end

    ctrl_out_decode u_dec (
        .state     (state),
        .is_bne    (op_q == OP_BNE),
`ifdef MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign pc_source     = ctrl.pc_source;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign illegal       = ctrl.illegal;
    assign state_o       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver expands each instruction into its expected
// per-cycle (state, controls, instret) tuples and queues them; a negedge
// monitor pops and compares one tuple per cycle.
module tb_multicycle_control;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3,
                   S_MEM_READ = 4, S_MEM_WB = 5, S_MEM_WRITE = 6, S_R_EXEC = 7,
                   S_R_WB = 8, S_ADDI_EXEC = 9, S_ADDI_WB = 10, S_BRANCH = 11,
                   S_JUMP = 12, S_JR = 13, S_ILLEGAL = 14;

    logic        clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [2:0]  opcode = '0;
    logic [5:0]  func = '0;
    logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]  pc_source, alu_src_b, alu_op;
    logic [31:0] instret;
    logic [3:0]  state_o;

    multicycle_control #(.INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
        .instret(instret), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [17:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   seq[$];
    int   checks = 0, errors = 0;
    int   retired = 0;

    wire [17:0] dut_ctl = {pc_write, pc_write_cond, branch_ne, pc_source, iord,
                           mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                           reg_write, alu_src_a, alu_src_b, alu_op, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control word per state, straight from the state table
    function automatic logic [17:0] exp_ctrl(input int s, input logic bne);
        logic pw, pwc, bn, io, mr, mw, irw, m2r, rd, rw, sa, il;
        logic [1:0] ps, sb, op;
        {pw, pwc, bn, io, mr, mw, irw, m2r, rd, rw, sa, il} = '0;
        ps = 2'b00; sb = 2'b00; op = 2'b00;
        case (s)
            S_FETCH:     begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
            S_DECODE:    sb = 2'b11;
            S_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
            S_MEM_READ:  begin mr = 1; io = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_MEM_WRITE: begin mw = 1; io = 1; end
            S_R_EXEC:    begin sa = 1; op = 2'b10; end
            S_R_WB:      begin rw = 1; rd = 1; end
            S_ADDI_EXEC: begin sa = 1; sb = 2'b10; end
            S_ADDI_WB:   rw = 1;
            S_BRANCH:    begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; bn = bne; end
            S_JUMP:      begin pw = 1; ps = 2'b10; end
            S_JR:        begin pw = 1; ps = 2'b11; end
            S_ILLEGAL:   il = 1;
            default: ;
        endcase
        return {pw, pwc, bn, ps, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, il};
    endfunction

    // Instruction -> state walk
    function automatic void build_seq(input logic [2:0] op, input logic [5:0] fn);
        seq = '{S_FETCH, S_DECODE};
        case (op)
            3'b000: begin
                if (fn == 6'b001000) seq.push_back(S_JR);
                else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
                    seq.push_back(S_R_EXEC); seq.push_back(S_R_WB);
                end else seq.push_back(S_ILLEGAL);
            end
            3'b001: begin seq.push_back(S_ADDI_EXEC); seq.push_back(S_ADDI_WB); end
            3'b010: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_READ); seq.push_back(S_MEM_WB); end
            3'b011: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WRITE); end
            3'b100, 3'b101: seq.push_back(S_BRANCH);
            3'b110: seq.push_back(S_JUMP);
            default: seq.push_back(S_ILLEGAL);
        endcase
    endfunction

    // Run one instruction; with stop_at >= 0 only steps below stop_at are queued
    task automatic run_instr(input logic [2:0] op, input logic [5:0] fn, input int stop_at);
        exp_t e;
        int   n;
        build_seq(op, fn);
        n = (stop_at >= 0) ? stop_at : seq.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            e.st  = seq[k];
            e.ctl = exp_ctrl(seq[k], op == 3'b101);
            e.ret = retired;
            q.push_back(e);
            zero = 1'($urandom);
            if (k == 1) begin opcode = op; func = fn; end
            else begin opcode = 3'($urandom); func = 6'($urandom); end
        end
        if (stop_at < 0 && seq[seq.size()-1] != S_ILLEGAL) retired++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && q.size() > 0) begin
            e = q.pop_front();
            check("state", 32'(state_o), 32'(e.st));
            check("ctrl", 32'(dut_ctl), 32'(e.ctl));
            check("instret", instret, e.ret);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] dop [14] = '{3'b000, 3'b010, 3'b011, 3'b000, 3'b110, 3'b101, 3'b111,
                            3'b000, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [5:0] dfn [14] = '{6'b100000, 6'b0, 6'b0, 6'b001000, 6'b0, 6'b0, 6'b0,
                            6'b111111, 6'b0, 6'b0, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

    task automatic random_instrs(input int cnt);
        logic [5:0] fn;
        for (int i = 0; i < cnt; i++) begin
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
            run_instr(3'($urandom), fn, -1);
        end
    endtask

    initial begin
        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_state", 32'(state_o), S_IDLE);
            check("rst_ctrl", 32'(dut_ctl), 32'd0);
            check("rst_instret", instret, 32'd0);
        end
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 14; i++) run_instr(dop[i], dfn[i], -1);
        random_instrs(80);

        // sw interrupted by reset while in MEM_WRITE
        run_instr(3'b011, 6'd0, 3);
        @(posedge clk); #1;
        check("mw_state", 32'(state_o), S_MEM_WRITE);
        check("mw_write", 32'({mem_write, iord}), 32'b11);
        #1 reset = 1'b1;
        #1;
        check("abort_write", 32'(mem_write), 32'd0);
        check("abort_state", 32'(state_o), S_IDLE);
        check("abort_instret", instret, 32'd0);
        retired = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(state_o), S_IDLE);

        random_instrs(30);
        @(negedge clk); #1;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
